// File: rtl/cpu7_icu_pkg.sv
// Shared definitions for the cpu7 instruction-cache fetch responder.
// Holds the FSM state codes, the block-offset constant and the block-address type.
package cpu7_icu_pkg;

   localparam logic [1:0] ICU_IDLE = 2'd0;
   localparam logic [1:0] ICU_REQ  = 2'd1;
   localparam logic [1:0] ICU_WAIT = 2'd2;

   localparam int ICU_BLK_LSB = 3;

   typedef logic [31-ICU_BLK_LSB:0] blk_t;

   function automatic blk_t blk_of(input logic [31:0] addr);
      return addr[31:ICU_BLK_LSB];
   endfunction

endpackage

// File: rtl/cpu7_icu_lbuf.sv
// One-entry line buffer: holds the tag and data of the last filled 64-bit block.
// Invalidate wins over a same-cycle fill.
module cpu7_icu_lbuf
   import cpu7_icu_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        fill,
   input  blk_t        fill_tag,
   input  logic [63:0] fill_data,
   input  logic        inv,
   input  blk_t        chk_tag,
   output logic        hit,
   output logic [63:0] data
);

   logic vld;
   blk_t tag;

   // Valid bit, tag and data storage.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld  <= 1'b0;
         tag  <= '0;
         data <= 64'h0;
      end else begin
         if (inv) begin
            vld <= 1'b0;
         end else if (fill) begin
            vld <= 1'b1;
         end
         if (fill) begin
            tag  <= fill_tag;
            data <= fill_data;
         end
      end
   end

   assign hit = vld && (tag == chk_tag);

endmodule

// File: rtl/cpu7_icu_fetch.sv
// IFU fetch responder: hits come from the line buffer, misses from the BIU.
// Only one request is outstanding; ack is combinational on the request cycle.
module cpu7_icu_fetch
   import cpu7_icu_pkg::*;
#(
   parameter bit LBUF_EN = 1'b1
)(
   input  logic        clk,
   input  logic        resetn,
   input  logic        ifu_icu_req_ic1,
   input  logic [31:0] ifu_icu_addr_ic1,
   input  logic        ifu_icu_cancel,
   input  logic        icu_inv,
   output logic        icu_ifu_ack_ic1,
   output logic [63:0] icu_ifu_data_ic2,
   output logic        icu_ifu_data_valid_ic2,
   output logic        icu_biu_req,
   output logic [31:0] icu_biu_addr,
   input  logic        biu_icu_ack,
   input  logic [63:0] biu_icu_data,
   input  logic        biu_icu_data_valid
);

   logic [1:0]  state;
   blk_t        blk_addr;
   logic        drop;
   logic        inv_pend;
   logic        hit_vld;
   logic        miss_vld;
   logic        lbuf_hit;
   logic [63:0] lbuf_data;
   logic        hit;
   logic        ack;
   logic        fill;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^ifu_icu_addr_ic1[ICU_BLK_LSB-1:0];

   // An invalidate in the same cycle as the hit check forces a miss.
   assign hit  = LBUF_EN && lbuf_hit && !icu_inv;
   assign ack  = (state == ICU_IDLE) && ifu_icu_req_ic1 && !ifu_icu_cancel && !miss_vld;
   assign fill = (state == ICU_WAIT) && biu_icu_data_valid && !inv_pend && !icu_inv;

   assign icu_ifu_ack_ic1        = ack;
   assign icu_ifu_data_valid_ic2 = (hit_vld && !ifu_icu_cancel) || miss_vld;
   assign icu_biu_addr           = {blk_addr, 3'b000};

   cpu7_icu_lbuf u_lbuf (
      .clk       (clk),
      .resetn    (resetn),
      .fill      (fill),
      .fill_tag  (blk_addr),
      .fill_data (biu_icu_data),
      .inv       (icu_inv),
      .chk_tag   (blk_of(ifu_icu_addr_ic1)),
      .hit       (lbuf_hit),
      .data      (lbuf_data)
   );

   // Request FSM, flush/invalidate bookkeeping and ic2 output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state            <= ICU_IDLE;
         blk_addr         <= '0;
         icu_biu_req      <= 1'b0;
         drop             <= 1'b0;
         inv_pend         <= 1'b0;
         hit_vld          <= 1'b0;
         miss_vld         <= 1'b0;
         icu_ifu_data_ic2 <= 64'h0;
      end else begin
         hit_vld  <= 1'b0;
         miss_vld <= 1'b0;
         case (state)
            ICU_IDLE: begin
               if (ack) begin
                  blk_addr <= blk_of(ifu_icu_addr_ic1);
                  if (hit) begin
                     icu_ifu_data_ic2 <= lbuf_data;
                     hit_vld          <= 1'b1;
                  end else begin
                     state       <= ICU_REQ;
                     icu_biu_req <= 1'b1;
                  end
               end
            end
            ICU_REQ: begin
               if (ifu_icu_cancel) begin
                  drop <= 1'b1;
               end
               if (biu_icu_ack) begin
                  icu_biu_req <= 1'b0;
                  state       <= ICU_WAIT;
               end
            end
            ICU_WAIT: begin
               if (biu_icu_data_valid) begin
                  icu_ifu_data_ic2 <= biu_icu_data;
                  miss_vld         <= !(drop || ifu_icu_cancel);
                  drop             <= 1'b0;
                  inv_pend         <= 1'b0;
                  state            <= ICU_IDLE;
               end else begin
                  if (ifu_icu_cancel) begin
                     drop <= 1'b1;
                  end
                  if (icu_inv) begin
                     inv_pend <= 1'b1;
                  end
               end
            end
            default: begin
               state       <= ICU_IDLE;
               icu_biu_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
